mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 141 ++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with architectural HI/LO: 5-cycle multiply, 10-cycle divide.
// MADD/MADDU are compiled in only when MDU_MADD_EN is defined.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        is_long;
    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_long = is_long || (op == OP_MADD) || (op == OP_MADDU);
`endif
    end

    assign busy      = (cnt != 4'd0);
    assign stall_req = busy | (start & is_long);
    assign md_out    = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : 32'd0;

    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        signed_op = signed_op || (op_q == OP_MADD);
`endif
    end

    // Low 64 bits of the product of the extended operands are correct for both signednesses.
    assign a_ext = signed_op ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign b_ext = signed_op ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = a_ext * b_ext;

    // Signed divide is done on magnitudes; the most negative dividend maps onto itself,
    // which makes 0x80000000 / -1 come out as 0x80000000 remainder 0.
    assign a_neg = signed_op & a_q[31];
    assign b_neg = signed_op & b_q[31];
    assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= 4'd0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                case (op_q)
                    OP_MULT, OP_MULTU: {hi, lo} <= prod;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            lo <= quot;
                            hi <= rem;
                        end
                    end
`ifdef MDU_MADD_EN
                    // HI/LO cannot change while busy, so they still hold the accepting-edge values.
                    OP_MADD, OP_MADDU: {hi, lo} <= {hi, lo} + prod;
`endif
                    default: ;
                endcase
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= MUL_LAT;
                end
                OP_DIV, OP_DIVU: begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= DIV_LAT;
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= MUL_LAT;
                end
`endif
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboarded random/directed bench for mul_div_unit against an arithmetic HI/LO model.
// Build with MDU_MADD_EN defined to exercise MADD/MADDU.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .md_out(md_out)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [63:0] exp_q[$];
    logic        abort_flag = 0;
    logic        busy_prev = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic tb_is_long(input logic [3:0] o);
        logic r;
        r = (o >= 4'd1 && o <= 4'd4);
`ifdef MDU_MADD_EN
        r = r || o == 4'd9 || o == 4'd10;
`endif
        return r;
    endfunction

    // Reference model: HI/LO effect of an accepted operation, computed arithmetically.
    task automatic model_issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int sx, sy;
        sx = x;
        sy = y;
        lat = 0;
        case (o)
            4'd1: begin {m_hi, m_lo} = longint'(sx) * longint'(sy); lat = 5; end
            4'd2: begin {m_hi, m_lo} = {32'd0, x} * {32'd0, y}; lat = 5; end
            4'd3: begin
                lat = 10;
                if (y != 0) begin
                    if (x == 32'h80000000 && y == 32'hffffffff) begin
                        m_lo = 32'h80000000; m_hi = 32'd0;
                    end else begin
                        m_lo = sx / sy; m_hi = sx % sy;
                    end
                end
            end
            4'd4: begin lat = 10; if (y != 0) begin m_lo = x / y; m_hi = x % y; end end
            4'd5: m_hi = x;
            4'd6: m_lo = x;
`ifdef MDU_MADD_EN
            4'd9:  begin {m_hi, m_lo} = {m_hi, m_lo} + longint'(sx) * longint'(sy); lat = 5; end
            4'd10: begin {m_hi, m_lo} = {m_hi, m_lo} + {32'd0, x} * {32'd0, y}; lat = 5; end
`endif
            default: ;
        endcase
        if (lat != 0) exp_q.push_back({m_hi, m_lo});
    endtask

    // Monitor: every completion (busy falling) must match the head of the expected queue.
    always @(negedge clk) begin
        if (busy_prev && !busy) begin
            if (abort_flag) abort_flag = 0;
            else if (exp_q.size() == 0) check("unexpected_commit", 64'd1, 64'd0);
            else check("commit_hilo", {hi, lo}, exp_q.pop_front());
        end
        busy_prev = busy;
    end

    // Issue one op; inject>0 drives a second MULT start on that busy cycle (must be ignored).
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int inject);
        logic [63:0] pre;
        int lat, n;
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        #1;
        check("stall_req_issue", {63'd0, stall_req}, {63'd0, tb_is_long(o)});
        pre = {m_hi, m_lo};
        model_issue(o, x, y, lat);
        @(negedge clk);
        start = 0; op = 4'd0; a = $urandom; b = $urandom;
        if (lat == 0) begin
            check("no_busy", {63'd0, busy}, 64'd0);
            check("direct_hilo", {hi, lo}, {m_hi, m_lo});
        end else begin
            n = 0;
            while (busy && n < 20) begin
                check("hilo_hold", {hi, lo}, pre);
                check("stall_busy", {63'd0, stall_req}, 64'd1);
                n++;
                if (n == inject) begin start = 1; op = 4'd1; a = $urandom; b = $urandom; end
                else begin start = 0; op = 4'd0; end
                @(negedge clk);
            end
            start = 0; op = 4'd0;
            check("busy_cycles", 64'(n), 64'(lat));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] rx, ry;
        int inj;
        rst = 1; start = 0; op = 0; a = 0; b = 0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {62'd0, busy, stall_req}, 64'd0);
        rst = 0;

        // Directed corners.
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 0);
        check("mult_corner", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(4'd4, 32'd100, 32'd7, 0);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        run_op(4'd3, -32'sd7, 32'd2, 0);
        check("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_overflow", {hi, lo}, {32'd0, 32'h80000000});
        run_op(4'd5, 32'h12345678, 32'd0, 0);
        @(negedge clk); op = 4'd7; #1;
        check("mfhi_md_out", {32'd0, md_out}, {32'd0, 32'h12345678});
        op = 4'd8; #1;
        check("mflo_md_out", {32'd0, md_out}, {32'd0, m_lo});
        op = 4'd0; #1;
        check("none_md_out", {32'd0, md_out}, 64'd0);
        run_op(4'd3, 32'd55, 32'd0, 0);
        check("div_by_zero", {hi, lo}, {32'h12345678, m_lo});
        run_op(4'd1, 32'd1000, 32'd2000, 2);
        check("mult_inject", {hi, lo}, 64'd2000000);
        run_op(4'd7, 32'hdead, 32'hbeef, 0);
        run_op(4'd6, 32'd10, 32'd0, 0);
        run_op(4'd5, 32'd0, 32'd0, 0);
        run_op(4'd9, 32'd3, 32'd4, 0);
`ifdef MDU_MADD_EN
        check("madd", {hi, lo}, {32'd0, 32'd22});
`else
        check("madd_disabled", {hi, lo}, {32'd0, 32'd10});
`endif

        // Abort a DIVU on its 4th busy cycle; reset also wins over a same-edge start.
        @(negedge clk); start = 1; op = 4'd4; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 0; op = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1; start = 1; op = 4'd1; abort_flag = 1;
        m_hi = 0; m_lo = 0;
        @(negedge clk); rst = 0; start = 0; op = 4'd0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_commit", {31'd0, busy, hi, lo}, 64'd0);
        abort_flag = 0;

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) ro = 4'($urandom_range(1, 6));
            rx = $urandom; ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 0;
                1: ry = 32'hFFFFFFFF;
                2: rx = 32'h80000000;
                3: ry = 32'($urandom_range(1, 20));
                default: ;
            endcase
            inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0;
            run_op(ro, rx, ry, inj);
        end

        @(negedge clk);
        check("final_hilo", {hi, lo}, {m_hi, m_lo});
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
